// File: rtl/sdram_device_responder.sv
// Synthesizable SDRAM device model: decodes controller commands, tracks mode,
// the open row and bursts, keeps data in a small word array and returns read
// data after the programmed CAS latency.
module sdram_device_responder #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 13,
    parameter int ROW_BITS = 2,
    parameter int COL_BITS = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                io_sdram_control_cs,
    input  logic                io_sdram_control_ras,
    input  logic                io_sdram_control_cas,
    input  logic                io_sdram_control_we,
    input  logic [ADDR_W-1:0]   io_sdram_control_address_bus,
    input  logic [DATA_W/8-1:0] io_sdram_control_dqm,
    input  logic [DATA_W-1:0]   io_dq_in,
    output logic [DATA_W-1:0]   io_dq_out,
    output logic                io_dq_oe,
    output logic [2:0]          io_state_out,
    output logic                io_protocol_error,
    output logic [15:0]         io_refresh_count
);

    localparam int DQM_W = DATA_W / 8;
    localparam int IDX_W = ROW_BITS + COL_BITS;
    localparam int DEPTH = 2 ** IDX_W;

    typedef enum logic [2:0] {
        ST_INIT     = 3'd0,
        ST_IDLE     = 3'd1,
        ST_ROW_OPEN = 3'd2,
        ST_READ     = 3'd3,
        ST_WRITE    = 3'd4
    } state_t;

    typedef enum logic [3:0] {
        CMD_DESEL, CMD_NOP, CMD_ACTIVE, CMD_READ, CMD_WRITE,
        CMD_PRECHARGE, CMD_REFRESH, CMD_LOAD_MODE, CMD_BURST_STOP
    } cmd_t;

    state_t               state, state_nxt;
    cmd_t                 cmd;
    logic [1:0]           bl_code, bl_nxt;      // burst length = 1 << bl_code
    logic                 cl3, cl3_nxt;         // 0: CAS latency 2, 1: CAS latency 3
    logic [ROW_BITS-1:0]  row, row_nxt;
    logic [COL_BITS-1:0]  burst_col, col_nxt;   // column of the next burst word
    logic [3:0]           burst_rem, rem_nxt;   // burst words still to transfer
    logic                 error_q, err_set;
    logic [15:0]          refresh_count, cnt_nxt;
    logic                 issue, issue_wr, cont;
    logic [COL_BITS-1:0]  issue_col, col_mask;
    logic [3:0]           bl_len;
    logic [IDX_W-1:0]     mem_idx;
    logic [DATA_W-1:0]    rd_data;
    logic                 rd_issue, wr_en;
    logic [1:0]           pipe_valid;
    logic [DATA_W-1:0]    pipe_data [2];
    logic [DATA_W-1:0]    dq_out_q;
    logic                 dq_oe_q;
    logic [DATA_W-1:0]    mem [DEPTH];
    logic                 unused_addr_bits;

    wire [ADDR_W-1:0] addr = io_sdram_control_address_bus;

    assign unused_addr_bits = ^addr[ADDR_W-1:7];

    // Next column inside the BL-aligned block (wraps, never crosses the block).
    function automatic logic [COL_BITS-1:0] wrap_inc(input logic [COL_BITS-1:0] col,
                                                     input logic [COL_BITS-1:0] mask);
        return (col & ~mask) | ((col + COL_BITS'(1)) & mask);
    endfunction

    // Command decode from the active-low strobes.
    always_comb begin
        if (io_sdram_control_cs) begin
            cmd = CMD_DESEL;
        end else begin
            case ({io_sdram_control_ras, io_sdram_control_cas, io_sdram_control_we})
                3'b111:  cmd = CMD_NOP;
                3'b011:  cmd = CMD_ACTIVE;
                3'b101:  cmd = CMD_READ;
                3'b100:  cmd = CMD_WRITE;
                3'b010:  cmd = CMD_PRECHARGE;
                3'b001:  cmd = CMD_REFRESH;
                3'b000:  cmd = CMD_LOAD_MODE;
                default: cmd = CMD_BURST_STOP;
            endcase
        end
    end

    assign bl_len   = 4'd1 << bl_code;
    assign col_mask = COL_BITS'(bl_len - 4'd1);

    // Next-state and datapath decisions; illegal commands only raise the error flag.
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latches).
        state_nxt = state;
        bl_nxt    = bl_code;
        cl3_nxt   = cl3;
        row_nxt   = row;
        col_nxt   = burst_col;
        rem_nxt   = burst_rem;
        cnt_nxt   = refresh_count;
        err_set   = 1'b0;
        issue     = 1'b0;
        issue_wr  = 1'b0;
        issue_col = burst_col;
        cont      = (state == ST_READ) || (state == ST_WRITE);

        case (cmd)
            CMD_LOAD_MODE: begin
                if ((state == ST_INIT || state == ST_IDLE) && !addr[2] &&
                    (addr[6:4] == 3'b010 || addr[6:4] == 3'b011)) begin
                    bl_nxt    = addr[1:0];
                    cl3_nxt   = addr[4];
                    state_nxt = ST_IDLE;
                end else begin
                    err_set = 1'b1;
                end
            end
            CMD_ACTIVE: begin
                if (state == ST_IDLE) begin
                    row_nxt   = addr[ROW_BITS-1:0];
                    state_nxt = ST_ROW_OPEN;
                end else begin
                    err_set = 1'b1;
                end
            end
            CMD_REFRESH: begin
                if (state == ST_IDLE) begin
                    if (refresh_count != 16'hFFFF) cnt_nxt = refresh_count + 16'd1;
                end else begin
                    err_set = 1'b1;
                end
            end
            CMD_PRECHARGE: begin
                if (state == ST_INIT) begin
                    err_set = 1'b1;
                end else if (state != ST_IDLE) begin
                    cont      = 1'b0;
                    state_nxt = ST_IDLE;
                end
            end
            CMD_BURST_STOP: begin
                if (state == ST_INIT) begin
                    err_set = 1'b1;
                end else if (cont) begin
                    cont      = 1'b0;
                    state_nxt = ST_ROW_OPEN;
                end
            end
            CMD_READ, CMD_WRITE: begin
                if (state == ST_ROW_OPEN || cont) begin
                    cont      = 1'b0;
                    issue     = 1'b1;
                    issue_wr  = (cmd == CMD_WRITE);
                    issue_col = addr[COL_BITS-1:0];
                    col_nxt   = wrap_inc(addr[COL_BITS-1:0], col_mask);
                    rem_nxt   = bl_len - 4'd1;
                    if (bl_code == 2'd0) state_nxt = ST_ROW_OPEN;
                    else                 state_nxt = (cmd == CMD_READ) ? ST_READ : ST_WRITE;
                end else begin
                    err_set = 1'b1;
                end
            end
            default: ;
        endcase

        if (cont) begin
            issue     = 1'b1;
            issue_wr  = (state == ST_WRITE);
            issue_col = burst_col;
            col_nxt   = wrap_inc(burst_col, col_mask);
            rem_nxt   = burst_rem - 4'd1;
            if (burst_rem == 4'd1) state_nxt = ST_ROW_OPEN;
        end
    end

    assign mem_idx  = {row, issue_col};
    assign rd_data  = mem[mem_idx];
    assign rd_issue = issue && !issue_wr;
    assign wr_en    = issue && issue_wr && !reset;

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= ST_INIT;
        else       state <= state_nxt;
    end

    // Mode, row, burst tracking, flags and the CAS-latency pipe.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bl_code       <= 2'd0;
            cl3           <= 1'b0;
            row           <= '0;
            burst_col     <= '0;
            burst_rem     <= '0;
            error_q       <= 1'b0;
            refresh_count <= '0;
            pipe_valid    <= '0;
            pipe_data[0]  <= '0;
            pipe_data[1]  <= '0;
            dq_out_q      <= '0;
            dq_oe_q       <= 1'b0;
        end else begin
            bl_code       <= bl_nxt;
            cl3           <= cl3_nxt;
            row           <= row_nxt;
            burst_col     <= col_nxt;
            burst_rem     <= rem_nxt;
            error_q       <= error_q | err_set;
            refresh_count <= cnt_nxt;
            dq_out_q      <= pipe_data[0];
            dq_oe_q       <= pipe_valid[0];
            pipe_valid[0] <= pipe_valid[1];
            pipe_data[0]  <= pipe_data[1];
            pipe_valid[1] <= 1'b0;
            pipe_data[1]  <= '0;
            if (rd_issue) begin
                if (cl3) begin
                    pipe_valid[1] <= 1'b1;
                    pipe_data[1]  <= rd_data;
                end else begin
                    pipe_valid[0] <= 1'b1;
                    pipe_data[0]  <= rd_data;
                end
            end
        end
    end

    // Byte-masked array write.
    // NOTE: the array has no reset so it maps onto RAM; contents survive reset.
    always_ff @(posedge clock) begin
        for (int i = 0; i < DQM_W; i++) begin
            if (wr_en && !io_sdram_control_dqm[i]) mem[mem_idx][i*8 +: 8] <= io_dq_in[i*8 +: 8];
        end
    end

    // Output drive.
    always_comb begin
        io_dq_out         = dq_out_q;
        io_dq_oe          = dq_oe_q;
        io_state_out      = state;
        io_protocol_error = error_q;
        io_refresh_count  = refresh_count;
    end

endmodule

// File: tb/tb_sdram_device_responder.sv
// Table-driven bench for sdram_device_responder plus a hand-written
// reset-during-write sequence.
module tb_sdram_device_responder;

    localparam logic [3:0] NOP = 4'b0111;
    localparam logic [3:0] ACT = 4'b0011;
    localparam logic [3:0] RD  = 4'b0101;
    localparam logic [3:0] WR  = 4'b0100;
    localparam logic [3:0] PRE = 4'b0010;
    localparam logic [3:0] REF = 4'b0001;
    localparam logic [3:0] LMR = 4'b0000;
    localparam logic [3:0] BST = 4'b0110;

    typedef struct {
        logic        rst;
        logic [3:0]  cmd;
        logic [12:0] addr;
        logic [1:0]  dqm;
        logic [15:0] din;
        logic [2:0]  st;
        logic        err;
        logic        oe;
        logic [15:0] dout;
        logic [15:0] cnt;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cs = 1'b0, ras = 1'b1, cas = 1'b1, we = 1'b1;
    logic [12:0] addr = '0;
    logic [1:0]  dqm = '0;
    logic [15:0] dq_in = '0;
    logic [15:0] dq_out;
    logic        dq_oe;
    logic [2:0]  state_out;
    logic        protocol_error;
    logic [15:0] refresh_count;

    int   n_vec = 0;
    int   n_bad = 0;
    vec_t vecs[$];

    always #5 clock = ~clock;

    sdram_device_responder dut (
        .clock                        (clock),
        .reset                        (reset),
        .io_sdram_control_cs          (cs),
        .io_sdram_control_ras         (ras),
        .io_sdram_control_cas         (cas),
        .io_sdram_control_we          (we),
        .io_sdram_control_address_bus (addr),
        .io_sdram_control_dqm         (dqm),
        .io_dq_in                     (dq_in),
        .io_dq_out                    (dq_out),
        .io_dq_oe                     (dq_oe),
        .io_state_out                 (state_out),
        .io_protocol_error            (protocol_error),
        .io_refresh_count             (refresh_count)
    );

    task automatic add(input logic r, input logic [3:0] c, input logic [12:0] a,
                       input logic [1:0] m, input logic [15:0] d, input logic [2:0] s,
                       input logic e, input logic o, input logic [15:0] q, input logic [15:0] n);
        vec_t v;
        v.rst = r; v.cmd = c; v.addr = a; v.dqm = m; v.din = d;
        v.st = s; v.err = e; v.oe = o; v.dout = q; v.cnt = n;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    // Drive one command for one cycle, leaving the bench just after the edge.
    task automatic step(input logic [3:0] c, input logic [12:0] a, input logic [15:0] d);
        {cs, ras, cas, we} = c;
        addr  = a;
        dqm   = 2'b00;
        dq_in = d;
        @(posedge clock);
        #1;
    endtask

    logic [15:0] exp_rd [4];

    initial begin
        // reset / READ before LOAD MODE
        add(1, NOP, 0, 0, 0,        0, 0, 0, 0, 0);
        add(0, NOP, 0, 0, 0,        0, 0, 0, 0, 0);
        add(0, RD,  0, 0, 0,        0, 0, 0, 0, 0);
        add(0, NOP, 0, 0, 0,        0, 1, 0, 0, 0);
        add(0, NOP, 0, 0, 0,        0, 1, 0, 0, 0);
        add(0, NOP, 0, 0, 0,        0, 1, 0, 0, 0);
        // BL4 CL2 write then read of row 1 cols 0..3
        add(1, NOP, 0, 0, 0,        0, 0, 0, 0, 0);
        add(0, LMR, 'h022, 0, 0,    0, 0, 0, 0, 0);
        add(0, ACT, 1, 0, 0,        1, 0, 0, 0, 0);
        add(0, WR,  0, 0, 'h00A0,   2, 0, 0, 0, 0);
        add(0, NOP, 0, 0, 'h00A1,   4, 0, 0, 0, 0);
        add(0, NOP, 0, 0, 'h00A2,   4, 0, 0, 0, 0);
        add(0, NOP, 0, 0, 'h00A3,   4, 0, 0, 0, 0);
        add(0, RD,  0, 0, 0,        2, 0, 0, 0, 0);
        add(0, NOP, 0, 0, 0,        3, 0, 0, 0, 0);
        add(0, NOP, 0, 0, 0,        3, 0, 1, 'h00A0, 0);
        add(0, NOP, 0, 0, 0,        3, 0, 1, 'h00A1, 0);
        add(0, NOP, 0, 0, 0,        2, 0, 1, 'h00A2, 0);
        add(0, NOP, 0, 0, 0,        2, 0, 1, 'h00A3, 0);
        // fill cols 4..7, then CL3 BL4 read from col 6 (wraps 6,7,4,5)
        add(0, WR,  4, 0, 'h00B4,   2, 0, 0, 0, 0);
        add(0, NOP, 0, 0, 'h00B5,   4, 0, 0, 0, 0);
        add(0, NOP, 0, 0, 'h00B6,   4, 0, 0, 0, 0);
        add(0, NOP, 0, 0, 'h00B7,   4, 0, 0, 0, 0);
        add(0, PRE, 0, 0, 0,        2, 0, 0, 0, 0);
        add(0, LMR, 'h032, 0, 0,    1, 0, 0, 0, 0);
        add(0, ACT, 1, 0, 0,        1, 0, 0, 0, 0);
        add(0, RD,  6, 0, 0,        2, 0, 0, 0, 0);
        add(0, NOP, 0, 0, 0,        3, 0, 0, 0, 0);
        add(0, NOP, 0, 0, 0,        3, 0, 0, 0, 0);
        add(0, NOP, 0, 0, 0,        3, 0, 1, 'h00B6, 0);
        add(0, NOP, 0, 0, 0,        2, 0, 1, 'h00B7, 0);
        add(0, NOP, 0, 0, 0,        2, 0, 1, 'h00B4, 0);
        add(0, NOP, 0, 0, 0,        2, 0, 1, 'h00B5, 0);
        // BL1 CL2 byte-masked write
        add(0, PRE, 0, 0, 0,        2, 0, 0, 0, 0);
        add(0, LMR, 'h020, 0, 0,    1, 0, 0, 0, 0);
        add(0, ACT, 2, 0, 0,        1, 0, 0, 0, 0);
        add(0, WR,  3, 2'b00, 'h1234, 2, 0, 0, 0, 0);
        add(0, WR,  3, 2'b10, 'hFFFF, 2, 0, 0, 0, 0);
        add(0, RD,  3, 2'b11, 0,    2, 0, 0, 0, 0);
        add(0, NOP, 0, 0, 0,        2, 0, 0, 0, 0);
        add(0, NOP, 0, 0, 0,        2, 0, 1, 'h12FF, 0);
        // BL8: full write, then a write cut short by PRECHARGE after 3 words
        add(0, PRE, 0, 0, 0,        2, 0, 0, 0, 0);
        add(0, LMR, 'h023, 0, 0,    1, 0, 0, 0, 0);
        add(0, ACT, 2, 0, 0,        1, 0, 0, 0, 0);
        add(0, WR,  8, 0, 'hC000,   2, 0, 0, 0, 0);
        for (int i = 1; i < 8; i++) add(0, NOP, 0, 0, 16'hC000 + 16'(i), 4, 0, 0, 0, 0);
        add(0, WR,  8, 0, 'hD000,   2, 0, 0, 0, 0);
        add(0, NOP, 0, 0, 'hD001,   4, 0, 0, 0, 0);
        add(0, NOP, 0, 0, 'hD002,   4, 0, 0, 0, 0);
        add(0, PRE, 0, 0, 'hEEEE,   4, 0, 0, 0, 0);
        add(0, ACT, 2, 0, 0,        1, 0, 0, 0, 0);
        add(0, RD,  8, 0, 0,        2, 0, 0, 0, 0);
        add(0, NOP, 0, 0, 0,        3, 0, 0, 0, 0);
        add(0, NOP, 0, 0, 0,        3, 0, 1, 'hD000, 0);
        add(0, NOP, 0, 0, 0,        3, 0, 1, 'hD001, 0);
        add(0, NOP, 0, 0, 0,        3, 0, 1, 'hD002, 0);
        add(0, NOP, 0, 0, 0,        3, 0, 1, 'hC003, 0);
        add(0, NOP, 0, 0, 0,        3, 0, 1, 'hC004, 0);
        add(0, NOP, 0, 0, 0,        3, 0, 1, 'hC005, 0);
        add(0, NOP, 0, 0, 0,        2, 0, 1, 'hC006, 0);
        add(0, NOP, 0, 0, 0,        2, 0, 1, 'hC007, 0);
        // refresh counting and refresh with a row open
        add(0, PRE, 0, 0, 0,        2, 0, 0, 0, 0);
        add(0, REF, 0, 0, 0,        1, 0, 0, 0, 0);
        add(0, REF, 0, 0, 0,        1, 0, 0, 0, 1);
        add(0, REF, 0, 0, 0,        1, 0, 0, 0, 2);
        add(0, ACT, 0, 0, 0,        1, 0, 0, 0, 3);
        add(0, REF, 0, 0, 0,        2, 0, 0, 0, 3);
        add(0, NOP, 0, 0, 0,        2, 1, 0, 0, 3);
        // BURST STOP, read interrupting read, reset flushing the CL pipe
        add(1, NOP, 0, 0, 0,        0, 0, 0, 0, 0);
        add(0, LMR, 'h022, 0, 0,    0, 0, 0, 0, 0);
        add(0, ACT, 1, 0, 0,        1, 0, 0, 0, 0);
        add(0, RD,  0, 0, 0,        2, 0, 0, 0, 0);
        add(0, BST, 0, 0, 0,        3, 0, 0, 0, 0);
        add(0, NOP, 0, 0, 0,        2, 0, 1, 'h00A0, 0);
        add(0, RD,  4, 0, 0,        2, 0, 0, 0, 0);
        add(0, RD,  0, 0, 0,        3, 0, 0, 0, 0);
        add(0, NOP, 0, 0, 0,        3, 0, 1, 'h00B4, 0);
        add(0, NOP, 0, 0, 0,        3, 0, 1, 'h00A0, 0);
        add(0, NOP, 0, 0, 0,        3, 0, 1, 'h00A1, 0);
        add(1, NOP, 0, 0, 0,        0, 0, 0, 0, 0);
        add(0, NOP, 0, 0, 0,        0, 0, 0, 0, 0);

        @(posedge clock);
        #1;
        foreach (vecs[i]) begin
            reset = vecs[i].rst;
            {cs, ras, cas, we} = vecs[i].cmd;
            addr  = vecs[i].addr;
            dqm   = vecs[i].dqm;
            dq_in = vecs[i].din;
            @(negedge clock);
            n_vec++;
            if ({state_out, protocol_error, dq_oe, dq_out, refresh_count} !==
                {vecs[i].st, vecs[i].err, vecs[i].oe, vecs[i].dout, vecs[i].cnt}) begin
                n_bad++;
                $display("FAIL vec%0d: got state=%0d err=%0d oe=%0d dq=%h cnt=%0d, want state=%0d err=%0d oe=%0d dq=%h cnt=%0d",
                         i, state_out, protocol_error, dq_oe, dq_out, refresh_count,
                         vecs[i].st, vecs[i].err, vecs[i].oe, vecs[i].dout, vecs[i].cnt);
            end
            @(posedge clock);
            #1;
        end

        // Reset asserted mid-write: the word in flight must not land in the array.
        reset = 1'b0;
        step(LMR, 'h022, 0);
        step(ACT, 3, 0);
        step(WR, 0, 'h5555);
        repeat (3) step(NOP, 0, 'h5555);
        step(PRE, 0, 0);
        step(ACT, 3, 0);
        step(WR, 0, 'h1111);
        step(NOP, 0, 'h2222);
        check("mid_write_state", 32'(state_out), 32'd4);
        {cs, ras, cas, we} = NOP;
        dq_in = 16'h3333;
        reset = 1'b1;
        #1;
        check("reset_state", 32'(state_out), 32'd0);
        check("reset_oe", 32'(dq_oe), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        step(LMR, 'h022, 0);
        step(ACT, 3, 0);
        step(RD, 0, 0);
        check("rd_t1_oe", 32'(dq_oe), 32'd0);
        exp_rd[0] = 16'h1111;
        exp_rd[1] = 16'h2222;
        exp_rd[2] = 16'h5555;
        exp_rd[3] = 16'h5555;
        for (int k = 0; k < 4; k++) begin
            step(NOP, 0, 0);
            check($sformatf("rst_rd_word%0d", k), {15'd0, dq_oe, dq_out}, {15'd0, 1'b1, exp_rd[k]});
        end
        step(NOP, 0, 0);
        check("rst_rd_done_oe", 32'(dq_oe), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
